// File: rtl/dtlb_pkg.sv
// Shared translation types: walker response, TLB entry layout, page-size codes
// and the helpers for PA forming and permission checks.
package dtlb_pkg;

  localparam logic [1:0] PGSZ_1G = 2'd0;
  localparam logic [1:0] PGSZ_2M = 2'd1;
  localparam logic [1:0] PGSZ_4K = 2'd2;

  typedef struct packed {
    logic [63:0] paddr;
    logic        fault;
    logic        dirty;
    logic        readable;
    logic        writable;
    logic        executable;
    logic        user;
    logic [1:0]  pgsize;
  } page_walk_rsp_t;

  typedef struct packed {
    logic        valid;
    logic [26:0] vpn;
    logic [1:0]  pgsize;
    logic [51:0] pa;
    logic        dirty;
    logic        readable;
    logic        writable;
    logic        user;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Splices the page frame with the in-page offset for the given page size.
  function automatic logic [63:0] form_pa(input logic [51:0] pa, input logic [1:0] pgsize,
                                          input logic [29:0] va_off);
    case (pgsize)
      PGSZ_1G: form_pa = {pa[51:18], va_off[29:0]};
      PGSZ_2M: form_pa = {pa[51:9], va_off[20:0]};
      default: form_pa = {pa, va_off[11:0]};
    endcase
  endfunction

  function automatic logic is_canonical(input logic [63:0] va);
    return (&va[63:38]) | ~(|va[63:38]);
  endfunction

  function automatic logic perm_fault(input logic store, input logic readable,
                                     input logic writable);
    return store ? ~writable : ~readable;
  endfunction

endpackage

// File: rtl/dtlb_match.sv
// Combinational compare of one virtual address against one TLB entry,
// honouring the entry's page size, plus the physical address it would produce.
module tlb_match
  import dtlb_pkg::*;
(
  input  tlb_entry_t  entry,
  input  logic [38:0] va,
  output logic        match,
  output logic [63:0] pa
);

  logic [26:0] vpn;
  assign vpn = va[38:12];

  always_comb begin
    match = 1'b0;
    if (entry.valid) begin
      case (entry.pgsize)
        PGSZ_1G: match = (entry.vpn[26:18] == vpn[26:18]);
        PGSZ_2M: match = (entry.vpn[26:9] == vpn[26:9]);
        default: match = (entry.vpn == vpn);
      endcase
    end
  end

  assign pa = form_pa(entry.pa, entry.pgsize, va[29:0]);

endmodule

// File: rtl/dtlb.sv
// Fully associative data TLB: single-cycle hits, one outstanding page walk on
// a miss, installs non-faulting walk results into the victim entry.
module dtlb
  import dtlb_pkg::*;
#(
  parameter int N_ENTRIES = 8,
  localparam int LG_N = $clog2(N_ENTRIES)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear_tlb,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [63:0]    req_va,
  input  logic           req_store,
  output logic           rsp_valid,
  output logic [63:0]    rsp_pa,
  output logic           rsp_fault,
  output logic           rsp_dirty,
  output logic           rsp_user,
  output logic           rsp_hit,
  output logic           walk_req,
  output logic [63:0]    walk_va,
  input  logic           walk_rsp_valid,
  input  page_walk_rsp_t walk_rsp,
  output logic [1:0]     dbg_state
);

  // Handshake: a request transfers on a cycle where req_valid && req_ready;
  // req_ready is high only in IDLE, rsp_valid is a single-cycle pulse with no
  // backpressure, and walk_req is a single-cycle pulse with walk_va held
  // until walk_rsp_valid.

  tlb_entry_t       entries [N_ENTRIES];
  logic [LG_N-1:0]  repl_ptr;
  state_t           state, state_nxt;
  logic [63:0]      va_q;
  logic             store_q;
  logic             stale_q;

  logic [N_ENTRIES-1:0] hit_vec;
  logic [63:0]          hit_pa [N_ENTRIES];
  logic                 hit_any, has_free, canon, accept, lookup_hit, walk_done, fill_en;
  logic [LG_N-1:0]      hit_idx, free_idx, victim;
  tlb_entry_t           hit_entry;
  logic                 unused_rsp_bits;

  assign unused_rsp_bits = ^{walk_rsp.executable, walk_rsp.paddr[11:0]};

  for (genvar g = 0; g < N_ENTRIES; g++) begin : g_match
    tlb_match u_match (
      .entry (entries[g]),
      .va    (req_va[38:0]),
      .match (hit_vec[g]),
      .pa    (hit_pa[g])
    );
  end

  // Descending scans so the lowest index wins for both hit and free slot.
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_any = 1'b1;
        hit_idx = LG_N'(i);
      end
      if (!entries[i].valid) begin
        has_free = 1'b1;
        free_idx = LG_N'(i);
      end
    end
  end

  assign victim     = has_free ? free_idx : repl_ptr;
  assign hit_entry  = entries[hit_idx];
  assign req_ready  = (state == ST_IDLE);
  assign accept     = req_valid & req_ready;
  assign canon      = is_canonical(req_va);
  assign lookup_hit = canon & hit_any & ~clear_tlb;
  assign walk_done  = (state == ST_WAIT) & walk_rsp_valid;
  assign fill_en    = walk_done & ~walk_rsp.fault & ~stale_q;
  assign walk_va    = va_q;
  assign dbg_state  = state;

  always_comb begin
    state_nxt = state;
    walk_req  = 1'b0;
    case (state)
      ST_IDLE: if (accept && canon && !lookup_hit) state_nxt = ST_WALK;
      ST_WALK: begin
        walk_req  = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: if (walk_rsp_valid) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      rsp_valid <= 1'b0;
      rsp_pa    <= '0;
      rsp_fault <= 1'b0;
      rsp_dirty <= 1'b0;
      rsp_user  <= 1'b0;
      rsp_hit   <= 1'b0;
      va_q      <= '0;
      store_q   <= 1'b0;
      stale_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= 1'b0;
      if (accept) begin
        if (!canon) begin
          rsp_valid <= 1'b1;
          rsp_pa    <= '0;
          rsp_fault <= 1'b1;
          rsp_dirty <= 1'b0;
          rsp_user  <= 1'b0;
          rsp_hit   <= 1'b0;
        end else if (lookup_hit) begin
          rsp_valid <= 1'b1;
          rsp_pa    <= hit_pa[hit_idx];
          rsp_fault <= perm_fault(req_store, hit_entry.readable, hit_entry.writable);
          rsp_dirty <= hit_entry.dirty;
          rsp_user  <= hit_entry.user;
          rsp_hit   <= 1'b1;
        end else begin
          va_q    <= req_va;
          store_q <= req_store;
          stale_q <= 1'b0;
        end
      end
      // A flush while the walk is in flight makes its result unsafe to cache.
      if (state != ST_IDLE && clear_tlb) stale_q <= 1'b1;
      if (walk_done) begin
        rsp_valid <= 1'b1;
        rsp_pa    <= form_pa(walk_rsp.paddr[63:12], walk_rsp.pgsize, va_q[29:0]);
        rsp_fault <= walk_rsp.fault |
                     perm_fault(store_q, walk_rsp.readable, walk_rsp.writable);
        rsp_dirty <= walk_rsp.dirty;
        rsp_user  <= walk_rsp.user;
        rsp_hit   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_tlb) begin
      for (int i = 0; i < N_ENTRIES; i++) entries[i].valid <= 1'b0;
      repl_ptr <= '0;
    end else if (fill_en) begin
      entries[victim] <= '{valid:    1'b1,
                           vpn:      va_q[38:12],
                           pgsize:   walk_rsp.pgsize,
                           pa:       walk_rsp.paddr[63:12],
                           dirty:    walk_rsp.dirty,
                           readable: walk_rsp.readable,
                           writable: walk_rsp.writable,
                           user:     walk_rsp.user};
      if (!has_free) repl_ptr <= repl_ptr + LG_N'(1);
    end
  end

endmodule

// File: tb/tb_dtlb.sv
// Directed bench for dtlb: expected responses are queued as requests are
// driven and compared as rsp_valid pulses arrive; a small walker model answers walks.
module tb_dtlb;
  import dtlb_pkg::*;

  logic           clk = 1'b0;
  logic           reset, clear_tlb, req_valid, req_ready, req_store;
  logic [63:0]    req_va, rsp_pa, walk_va;
  logic           rsp_valid, rsp_fault, rsp_dirty, rsp_user, rsp_hit, walk_req, walk_rsp_valid;
  page_walk_rsp_t walk_rsp;
  logic [1:0]     dbg_state;

  typedef struct packed {
    logic [63:0] pa;
    logic        fault;
    logic        hit;
    logic        chk_pa;
    logic        chk_hit;
    logic        one_cycle;
    logic [31:0] cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          walks = 0;
  int          w0;
  logic [31:0] cyc = 0;

  localparam logic [63:0] VA_A = 64'h0000_0000_4000_1234;
  localparam logic [63:0] VA_B = 64'h0000_0000_4020_0000;
  localparam logic [63:0] VA_C = 64'h0000_0000_5000_3000;
  localparam logic [63:0] VA_D = 64'h0000_0000_6000_5000;
  localparam logic [63:0] VA_E = 64'h0000_0000_7000_7000;

  dtlb #(.N_ENTRIES(8)) dut (
    .clk(clk), .reset(reset), .clear_tlb(clear_tlb),
    .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va), .req_store(req_store),
    .rsp_valid(rsp_valid), .rsp_pa(rsp_pa), .rsp_fault(rsp_fault), .rsp_dirty(rsp_dirty),
    .rsp_user(rsp_user), .rsp_hit(rsp_hit), .walk_req(walk_req), .walk_va(walk_va),
    .walk_rsp_valid(walk_rsp_valid), .walk_rsp(walk_rsp), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] pa, input logic fault, input logic hit,
                              input logic chk_pa, input logic chk_hit, input logic one);
    exp_t e;
    e = '{pa: pa, fault: fault, hit: hit, chk_pa: chk_pa, chk_hit: chk_hit,
          one_cycle: one, cyc: 32'd0};
    return e;
  endfunction

  // Scoreboard: every response pulse consumes the oldest expectation.
  exp_t e_mon;
  always @(negedge clk) begin
    if (walk_req === 1'b1) walks++;
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) check("rsp_unexpected", {63'd0, rsp_valid}, 64'd0);
      else begin
        e_mon = exp_q.pop_front();
        if (e_mon.chk_pa) check("rsp_pa", rsp_pa, e_mon.pa);
        check("rsp_fault", {63'd0, rsp_fault}, {63'd0, e_mon.fault});
        if (e_mon.chk_hit) check("rsp_hit", {63'd0, rsp_hit}, {63'd0, e_mon.hit});
        if (e_mon.one_cycle) check("rsp_latency", {32'd0, cyc}, {32'd0, e_mon.cyc + 32'd1});
      end
    end
  end

  task automatic issue(input logic [63:0] va, input logic st, input logic clr, input exp_t e);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready", {63'd0, req_ready}, 64'd1);
    req_va    = va;
    req_store = st;
    req_valid = 1'b1;
    clear_tlb = clr;
    e.cyc     = cyc;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    clear_tlb = 1'b0;
  endtask

  task automatic walker(input logic [63:0] va, input logic [63:0] paddr, input logic [1:0] pg,
                        input logic r, input logic w, input logic flt, input logic clr);
    int n = 0;
    @(negedge clk);
    while (walk_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("walk_req_seen", {63'd0, walk_req}, 64'd1);
    check("walk_va", walk_va, va);
    @(posedge clk); #1;
    check("walk_req_pulse", {63'd0, walk_req}, 64'd0);
    if (clr) begin
      clear_tlb = 1'b1;
      @(posedge clk); #1;
      clear_tlb = 1'b0;
    end
    walk_rsp          = '0;
    walk_rsp.paddr    = paddr;
    walk_rsp.pgsize   = pg;
    walk_rsp.readable = r;
    walk_rsp.writable = w;
    walk_rsp.fault    = flt;
    check("walk_va_hold", walk_va, va);
    walk_rsp_valid = 1'b1;
    @(posedge clk); #1;
    walk_rsp_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_clear();
    clear_tlb = 1'b1;
    @(posedge clk); #1;
    clear_tlb = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clear_tlb = 1'b0; req_valid = 1'b0; req_va = '0; req_store = 1'b0;
    walk_rsp_valid = 1'b0; walk_rsp = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("reset_rsp_fault", {63'd0, rsp_fault}, 64'd0);
    check("reset_rsp_hit", {63'd0, rsp_hit}, 64'd0);
    check("reset_walk_req", {63'd0, walk_req}, 64'd0);
    check("reset_rsp_pa", rsp_pa, 64'd0);
    check("reset_req_ready", {63'd0, req_ready}, 64'd1);

    // Cold 4K miss, then the same page hits one cycle later.
    w0 = walks;
    issue(VA_A, 1'b0, 1'b0, mk(64'h8020_1234, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    walker(VA_A, 64'h8020_1000, PGSZ_4K, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    check("cold_walks", 64'(walks - w0), 64'd1);
    issue(VA_A, 1'b0, 1'b0, mk(64'h8020_1234, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    drain();
    check("warm_walks", 64'(walks - w0), 64'd1);

    // 2M page reuse at a different in-page offset.
    issue(VA_B, 1'b0, 1'b0, mk(64'h9000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    walker(VA_B, 64'h9000_0000, PGSZ_2M, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    w0 = walks;
    issue(64'h402F_F008, 1'b0, 1'b0, mk(64'h900F_F008, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    drain();
    check("2m_hit_walks", 64'(walks - w0), 64'd0);

    // Store to a read-only page faults on the miss and on the hit; a load does not.
    issue(VA_C, 1'b1, 1'b0, mk(64'hA000_3000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
    walker(VA_C, 64'hA000_3000, PGSZ_4K, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();
    issue(VA_C, 1'b1, 1'b0, mk(64'hA000_3000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
    issue(VA_C + 64'h10, 1'b0, 1'b0, mk(64'hA000_3010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    drain();

    // Walker fault: no fill, the retry walks again.
    w0 = walks;
    issue(VA_D, 1'b0, 1'b0, mk(64'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    walker(VA_D, 64'd0, PGSZ_4K, 1'b1, 1'b1, 1'b1, 1'b0);
    drain();
    issue(VA_D, 1'b0, 1'b0, mk(64'hB000_5000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    walker(VA_D, 64'hB000_5000, PGSZ_4K, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    check("fault_refetch_walks", 64'(walks - w0), 64'd2);

    // Non-canonical address: immediate fault, never a walk.
    w0 = walks;
    issue(64'h0000_8000_0000_0000, 1'b0, 1'b0, mk(64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    drain();
    repeat (3) @(posedge clk); #1;
    check("noncanon_walks", 64'(walks - w0), 64'd0);

    // Flush during WAIT: response delivered, nothing installed.
    issue(VA_E, 1'b0, 1'b0, mk(64'hC000_7000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    walker(VA_E, 64'hC000_7000, PGSZ_4K, 1'b1, 1'b1, 1'b0, 1'b1);
    drain();
    w0 = walks;
    issue(VA_E, 1'b0, 1'b0, mk(64'hC000_7000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    walker(VA_E, 64'hC000_7000, PGSZ_4K, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    check("stale_walks", 64'(walks - w0), 64'd1);

    // Flush in IDLE: previously cached pages miss.
    pulse_clear();
    w0 = walks;
    issue(VA_E, 1'b0, 1'b0, mk(64'hC000_7000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    walker(VA_E, 64'hC000_7000, PGSZ_4K, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    issue(VA_A, 1'b0, 1'b0, mk(64'h8020_1234, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    walker(VA_A, 64'h8020_1000, PGSZ_4K, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    check("idle_clear_walks", 64'(walks - w0), 64'd2);

    // Four back-to-back hits on consecutive cycles.
    w0 = walks;
    issue(VA_E + 64'h10, 1'b0, 1'b0, mk(64'hC000_7010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    issue(VA_A, 1'b0, 1'b0, mk(64'h8020_1234, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    issue(VA_E + 64'h20, 1'b0, 1'b0, mk(64'hC000_7020, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    issue(VA_A + 64'h8, 1'b0, 1'b0, mk(64'h8020_123C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    drain();
    check("b2b_walks", 64'(walks - w0), 64'd0);

    // Flush coincident with an accept forces a miss.
    w0 = walks;
    issue(VA_E, 1'b0, 1'b1, mk(64'hC000_7000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    walker(VA_E, 64'hC000_7000, PGSZ_4K, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    check("accept_clear_walks", 64'(walks - w0), 64'd1);

    // Replacement: nine pages into eight entries evicts entry 0.
    pulse_clear();
    for (int i = 0; i < 9; i++) begin
      issue(64'h1000_0000 + 64'(i) * 64'h1000, 1'b0, 1'b0,
            mk(64'h2000_0000 + 64'(i) * 64'h1000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
      walker(64'h1000_0000 + 64'(i) * 64'h1000, 64'h2000_0000 + 64'(i) * 64'h1000,
             PGSZ_4K, 1'b1, 1'b1, 1'b0, 1'b0);
      drain();
    end
    w0 = walks;
    issue(64'h1000_1000, 1'b0, 1'b0, mk(64'h2000_1000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    drain();
    check("repl_page1_walks", 64'(walks - w0), 64'd0);
    issue(64'h1000_0000, 1'b0, 1'b0, mk(64'h2000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    walker(64'h1000_0000, 64'h2000_0000, PGSZ_4K, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    check("repl_page0_walks", 64'(walks - w0), 64'd1);

    // A stray walker response in IDLE must produce nothing.
    walk_rsp       = '0;
    walk_rsp.paddr = 64'hDEAD_0000;
    walk_rsp_valid = 1'b1;
    @(posedge clk); #1;
    walk_rsp_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("stray_rsp_state", {62'd0, dbg_state}, 64'd0);
    check("stray_rsp_ready", {63'd0, req_ready}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
